// File: rtl/arcade_input_mapper_if.sv
// Bundle of controller-side inputs and core-side control outputs for the arcade input mapper.
// The master side is the framework/bench; the mapper itself takes the slave view.
interface arcade_input_mapper_if #(
    parameter int PLAYERS = 2,
    parameter int BUTTONS = 2
);
    logic [10:0]                ps2_key;
    logic [16*PLAYERS-1:0]      joy;
    logic [1:0]                 rotate;
    logic                       joy_merge;
    logic                       coin_auto;
    logic [BUTTONS-1:0]         autofire_en;
    logic [4*PLAYERS-1:0]       o_dir;
    logic [BUTTONS*PLAYERS-1:0] o_btn;
    logic [PLAYERS-1:0]         o_start;
    logic [PLAYERS-1:0]         o_coin;

    modport master (
        output ps2_key, joy, rotate, joy_merge, coin_auto, autofire_en,
        input  o_dir, o_btn, o_start, o_coin
    );

    modport slave (
        input  ps2_key, joy, rotate, joy_merge, coin_auto, autofire_en,
        output o_dir, o_btn, o_start, o_coin
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 key map plus joysticks, screen rotation, autofire and
// coin stretching, producing registered (optionally active-low) control inputs for a core.
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int BUTTONS      = 2,
    parameter int COIN_HOLD    = 2457600,
    parameter int AUTOFIRE_DIV = 409600,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    arcade_input_mapper_if.slave  bus
);
    // Only players 1-2 and buttons 0-3 have keyboard keys.
    localparam int KP = (PLAYERS < 2) ? PLAYERS : 2;
    localparam int KB = (BUTTONS < 4) ? BUTTONS : 4;
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
    localparam int CW = $clog2(COIN_HOLD + 1);
    localparam int WW = 6 + BUTTONS;
    localparam logic INV = (ACTIVE_LOW != 0);

    // Direction codes ordered U,D,L,R; player 1 arrows match on the low byte only.
    localparam logic [8:0] DIR_CODE [2][4] = '{'{9'h075, 9'h072, 9'h06B, 9'h074},
                                               '{9'h02D, 9'h02B, 9'h023, 9'h034}};
    localparam logic [8:0] BTN_CODE [2][4] = '{'{9'h014, 9'h011, 9'h029, 9'h012},
                                               '{9'h01C, 9'h01B, 9'h015, 9'h01D}};
    localparam logic [8:0] START_A [2]     = '{9'h016, 9'h01E};
    localparam logic [8:0] START_B [2]     = '{9'h005, 9'h006};
    localparam logic [8:0] COIN_CODE [2]   = '{9'h02E, 9'h036};

    logic                  primed_reg;
    logic                  old_tog_reg;
    logic                  key_event;
    logic [8:0]            key_code;
    logic                  key_pressed;
    logic [KP-1:0][3:0]    key_dir_reg,   key_dir_next;
    logic [KP-1:0][KB-1:0] key_btn_reg,   key_btn_next;
    logic [KP-1:0]         key_start_reg, key_start_next;
    logic [KP-1:0]         key_coin_reg,  key_coin_next;

    logic [AW-1:0]         af_cnt_reg;
    logic                  phase_reg;
    logic [WW-1:0]         joy_or;

    logic [4*PLAYERS-1:0]       dir_q;
    logic [BUTTONS*PLAYERS-1:0] btn_q;
    logic [PLAYERS-1:0]         start_q;
    logic [PLAYERS-1:0]         coin_q;

    assign key_code    = bus.ps2_key[8:0];
    assign key_pressed = bus.ps2_key[9];
    assign key_event   = primed_reg & (bus.ps2_key[10] != old_tog_reg);

    always_comb begin
        key_dir_next   = key_dir_reg;
        key_btn_next   = key_btn_reg;
        key_start_next = key_start_reg;
        key_coin_next  = key_coin_reg;
        if (key_event) begin
            for (int p = 0; p < KP; p++) begin
                for (int j = 0; j < 4; j++) begin
                    if ((p == 0) ? (key_code[7:0] == DIR_CODE[0][j][7:0])
                                 : (key_code == DIR_CODE[p][j]))
                        key_dir_next[p][3-j] = key_pressed;
                end
                for (int k = 0; k < KB; k++) begin
                    if (key_code == BTN_CODE[p][k])
                        key_btn_next[p][k] = key_pressed;
                end
                if (key_code == START_A[p] || key_code == START_B[p])
                    key_start_next[p] = key_pressed;
                if (key_code == COIN_CODE[p])
                    key_coin_next[p] = key_pressed;
            end
        end
    end

    // The first clock after reset only captures the toggle level, so a stale toggle is not an event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed_reg    <= 1'b0;
            old_tog_reg   <= 1'b0;
            key_dir_reg   <= '0;
            key_btn_reg   <= '0;
            key_start_reg <= '0;
            key_coin_reg  <= '0;
        end else begin
            primed_reg    <= 1'b1;
            old_tog_reg   <= bus.ps2_key[10];
            key_dir_reg   <= key_dir_next;
            key_btn_reg   <= key_btn_next;
            key_start_reg <= key_start_next;
            key_coin_reg  <= key_coin_next;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt_reg <= '0;
            phase_reg  <= 1'b1;
        end else if (af_cnt_reg == AW'(AUTOFIRE_DIV - 1)) begin
            af_cnt_reg <= '0;
            phase_reg  <= ~phase_reg;
        end else begin
            af_cnt_reg <= af_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        joy_or = '0;
        for (int p = 0; p < PLAYERS; p++)
            joy_or = joy_or | bus.joy[16*p +: WW];
    end

    for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
        logic [WW-1:0]      word;
        logic [3:0]         kdir;
        logic               kstart;
        logic               kcoin;
        logic [BUTTONS-1:0] kbtn;
        logic [3:0]         raw_dir;
        logic [3:0]         rot_dir;
        logic [BUTTONS-1:0] raw_btn;
        logic [BUTTONS-1:0] btn_val;
        logic               raw_start;
        logic               coin_src;
        logic               src_d_reg;
        logic [CW-1:0]      hold_reg;
        logic [3:0]         dir_reg;
        logic [BUTTONS-1:0] btn_reg;
        logic               start_reg;
        logic               coin_reg;

        if (gi < KP) begin : g_key
            assign kdir   = key_dir_reg[gi];
            assign kstart = key_start_reg[gi];
            assign kcoin  = key_coin_reg[gi];
        end else begin : g_nokey
            assign kdir   = '0;
            assign kstart = 1'b0;
            assign kcoin  = 1'b0;
        end

        for (genvar bi = 0; bi < BUTTONS; bi++) begin : g_btn
            if (gi < KP && bi < KB) begin : g_kb
                assign kbtn[bi] = key_btn_reg[gi][bi];
            end else begin : g_nokb
                assign kbtn[bi] = 1'b0;
            end
            assign btn_val[bi] = raw_btn[bi] & (bus.autofire_en[bi] ? phase_reg : 1'b1);
        end

        assign word      = bus.joy_merge ? joy_or : bus.joy[16*gi +: WW];
        assign raw_dir   = kdir | word[3:0];
        assign raw_btn   = kbtn | word[4 +: BUTTONS];
        assign raw_start = kstart | word[4+BUTTONS];
        assign coin_src  = kcoin | word[5+BUTTONS] | (bus.coin_auto & raw_start);

        // Vectors are {U,D,L,R}.
        always_comb begin
            rot_dir = raw_dir;
            case (bus.rotate)
                2'd1:    rot_dir = {raw_dir[1], raw_dir[0], raw_dir[2], raw_dir[3]};
                2'd2:    rot_dir = {raw_dir[2], raw_dir[3], raw_dir[0], raw_dir[1]};
                2'd3:    rot_dir = {raw_dir[0], raw_dir[1], raw_dir[3], raw_dir[2]};
                default: rot_dir = raw_dir;
            endcase
        end

        // Rising edges arriving while the hold counter runs are dropped, never extending a pulse.
        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                src_d_reg <= 1'b0;
                hold_reg  <= '0;
                dir_reg   <= '0;
                btn_reg   <= '0;
                start_reg <= 1'b0;
                coin_reg  <= 1'b0;
            end else begin
                src_d_reg <= coin_src;
                if (hold_reg == '0) begin
                    if (coin_src & ~src_d_reg)
                        hold_reg <= CW'(COIN_HOLD);
                end else begin
                    hold_reg <= hold_reg - 1'b1;
                end
                dir_reg   <= rot_dir;
                btn_reg   <= btn_val;
                start_reg <= raw_start;
                coin_reg  <= (hold_reg != '0);
            end
        end

        assign dir_q[4*gi +: 4]             = dir_reg;
        assign btn_q[BUTTONS*gi +: BUTTONS] = btn_reg;
        assign start_q[gi]                  = start_reg;
        assign coin_q[gi]                   = coin_reg;
    end

    assign bus.o_dir   = dir_q   ^ {(4*PLAYERS){INV}};
    assign bus.o_btn   = btn_q   ^ {(BUTTONS*PLAYERS){INV}};
    assign bus.o_start = start_q ^ {PLAYERS{INV}};
    assign bus.o_coin  = coin_q  ^ {PLAYERS{INV}};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: 2 players, 2 buttons, 8-clock coin hold,
// 4-clock autofire phase, active-low outputs.
module tb_arcade_input_mapper;
    localparam int P  = 2;
    localparam int B  = 2;
    localparam int CH = 8;
    localparam int AD = 4;

    logic clk_sys = 1'b0;
    logic reset;
    logic tog = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper_if #(.PLAYERS(P), .BUTTONS(B)) bus ();

    arcade_input_mapper #(
        .PLAYERS(P), .BUTTONS(B), .COIN_HOLD(CH), .AUTOFIRE_DIV(AD), .ACTIVE_LOW(1)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus.slave)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, code};
        $display("key event: tog=%0b pressed=%0b code=%03h", tog, pressed, code);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.ps2_key = '0;
        bus.joy = '0;
        bus.rotate = 2'd0;
        bus.joy_merge = 1'b0;
        bus.coin_auto = 1'b0;
        bus.autofire_en = '0;
        step(2);
        n_checks++;
        if (bus.o_dir !== 8'hFF) begin n_fail++; $display("FAIL reset_dir: got %b want %b", bus.o_dir, 8'hFF); end
        n_checks++;
        if (bus.o_btn !== 4'hF) begin n_fail++; $display("FAIL reset_btn: got %b want %b", bus.o_btn, 4'hF); end
        n_checks++;
        if ({bus.o_start, bus.o_coin} !== 4'hF) begin n_fail++; $display("FAIL reset_start_coin: got %b want 1111", {bus.o_start, bus.o_coin}); end
        reset = 1'b0;
        step(2);
        n_checks++;
        if (bus.o_dir !== 8'hFF) begin n_fail++; $display("FAIL post_reset_dir: got %b want %b", bus.o_dir, 8'hFF); end
        $display("reset sequence done");
    endtask

    task automatic test_kbd_arrows;
        send_key(1'b1, 9'h075);
        step(1);
        n_checks++;
        if (bus.o_dir[3] !== 1'b1) begin n_fail++; $display("FAIL kbd_up_1edge: got %b want 1", bus.o_dir[3]); end
        step(1);
        n_checks++;
        if (bus.o_dir[3] !== 1'b0) begin n_fail++; $display("FAIL kbd_up_2edge: got %b want 0", bus.o_dir[3]); end
        send_key(1'b1, 9'h175);
        step(2);
        n_checks++;
        if (bus.o_dir[3] !== 1'b0) begin n_fail++; $display("FAIL kbd_up_ext: got %b want 0", bus.o_dir[3]); end
        send_key(1'b0, 9'h075);
        step(1);
        n_checks++;
        if (bus.o_dir[3] !== 1'b0) begin n_fail++; $display("FAIL kbd_rel_1edge: got %b want 0", bus.o_dir[3]); end
        step(1);
        n_checks++;
        if (bus.o_dir[3] !== 1'b1) begin n_fail++; $display("FAIL kbd_rel_2edge: got %b want 1", bus.o_dir[3]); end
        send_key(1'b1, 9'h02D);
        send_key(1'b1, 9'h02D);
        step(2);
        n_checks++;
        if (bus.o_dir !== 8'hFF) begin n_fail++; $display("FAIL kbd_p2_up_stale: got %b want %b", bus.o_dir, 8'hFF); end
        send_key(1'b1, 9'h02D);
        step(2);
        n_checks++;
        if (bus.o_dir !== 8'h7F) begin n_fail++; $display("FAIL kbd_p2_up: got %b want %b", bus.o_dir, 8'h7F); end
        send_key(1'b1, 9'h014);
        step(2);
        n_checks++;
        if (bus.o_btn !== 4'hE) begin n_fail++; $display("FAIL kbd_p1_btn0: got %b want %b", bus.o_btn, 4'hE); end
        send_key(1'b0, 9'h02D);
        step(1);
        send_key(1'b0, 9'h014);
        step(2);
        n_checks++;
        if ({bus.o_dir, bus.o_btn} !== 12'hFFF) begin n_fail++; $display("FAIL kbd_all_released: got %h want fff", {bus.o_dir, bus.o_btn}); end
    endtask

    task automatic test_rotation;
        logic [3:0] exp_rot [4];
        exp_rot = '{4'b1101, 4'b0111, 4'b1110, 4'b1011};
        bus.joy = 32'h0000_0002;
        for (int r = 0; r < 4; r++) begin
            bus.rotate = 2'(r);
            step(1);
            $display("rotate=%0d o_dir=%b", r, bus.o_dir);
            n_checks++;
            if (bus.o_dir !== {4'hF, exp_rot[r]}) begin
                n_fail++;
                $display("FAIL rotate_%0d: got %b want %b", r, bus.o_dir, {4'hF, exp_rot[r]});
            end
        end
        bus.rotate = 2'd0;
        bus.joy = '0;
        step(1);
    endtask

    task automatic test_coin_stretch;
        logic e;
        bus.joy[7] = 1'b1;
        step(1);
        for (int i = 1; i <= 19; i++) begin
            step(1);
            e = (i <= CH) ? 1'b0 : 1'b1;
            n_checks++;
            if (bus.o_coin !== {1'b1, e}) begin n_fail++; $display("FAIL coin_hold_%0d: got %b want %b", i, bus.o_coin, {1'b1, e}); end
        end
        bus.joy[7] = 1'b0;
        step(2);
        $display("coin pulse with retrigger");
        bus.joy[7] = 1'b1;
        step(1);
        bus.joy[7] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) bus.joy[7] = 1'b1;
            if (i == 5) bus.joy[7] = 1'b0;
            step(1);
            e = (i <= CH) ? 1'b0 : 1'b1;
            n_checks++;
            if (bus.o_coin[0] !== e) begin n_fail++; $display("FAIL coin_retrig_%0d: got %b want %b", i, bus.o_coin[0], e); end
        end
    endtask

    task automatic test_autofire;
        logic prev;
        logic v;
        logic e;
        bit   found;
        bus.autofire_en = 2'b01;
        bus.joy[4] = 1'b1;
        step(2);
        prev = bus.o_btn[0];
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.o_btn[0] !== prev) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL autofire_toggle: got constant %b want alternating", prev); end
        v = bus.o_btn[0];
        for (int j = 1; j < 12; j++) begin
            step(1);
            e = (((j / AD) % 2) == 0) ? v : ~v;
            n_checks++;
            if (bus.o_btn[0] !== e) begin n_fail++; $display("FAIL autofire_phase_%0d: got %b want %b", j, bus.o_btn[0], e); end
        end
        n_checks++;
        if (bus.o_btn[1] !== 1'b1) begin n_fail++; $display("FAIL autofire_btn1_idle: got %b want 1", bus.o_btn[1]); end
        bus.autofire_en = 2'b00;
        step(1);
        for (int j = 0; j < 8; j++) begin
            step(1);
            n_checks++;
            if (bus.o_btn[0] !== 1'b0) begin n_fail++; $display("FAIL autofire_off_%0d: got %b want 0", j, bus.o_btn[0]); end
        end
        bus.joy = '0;
        step(1);
        $display("autofire done");
    endtask

    task automatic test_merge_coin_auto;
        logic e;
        bus.joy_merge = 1'b1;
        bus.joy = 32'h0008_0000;
        step(1);
        n_checks++;
        if ({bus.o_dir[7], bus.o_dir[3]} !== 2'b00) begin n_fail++; $display("FAIL merge_up: got %b want 00", {bus.o_dir[7], bus.o_dir[3]}); end
        bus.joy_merge = 1'b0;
        step(1);
        n_checks++;
        if ({bus.o_dir[7], bus.o_dir[3]} !== 2'b01) begin n_fail++; $display("FAIL unmerged_up: got %b want 01", {bus.o_dir[7], bus.o_dir[3]}); end
        bus.joy = '0;
        step(1);
        bus.coin_auto = 1'b1;
        send_key(1'b1, 9'h01E);
        step(2);
        n_checks++;
        if ({bus.o_start, bus.o_coin} !== 4'b0111) begin n_fail++; $display("FAIL coin_auto_start: got %b want 0111", {bus.o_start, bus.o_coin}); end
        for (int i = 1; i <= 10; i++) begin
            step(1);
            e = (i <= CH) ? 1'b0 : 1'b1;
            n_checks++;
            if (bus.o_coin !== {e, 1'b1}) begin n_fail++; $display("FAIL coin_auto_pulse_%0d: got %b want %b", i, bus.o_coin, {e, 1'b1}); end
        end
        send_key(1'b0, 9'h01E);
        step(2);
        n_checks++;
        if (bus.o_start !== 2'b11) begin n_fail++; $display("FAIL coin_auto_release: got %b want 11", bus.o_start); end
        bus.coin_auto = 1'b0;
        step(CH + 2);
    endtask

    task automatic test_reset_mid_pulse;
        bus.joy[7] = 1'b1;
        step(1);
        step(3);
        n_checks++;
        if (bus.o_coin[0] !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_active: got %b want 0", bus.o_coin[0]); end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.o_dir, bus.o_btn, bus.o_start, bus.o_coin} !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h want ffff", {bus.o_dir, bus.o_btn, bus.o_start, bus.o_coin});
        end
        bus.joy = '0;
        step(2);
        reset = 1'b0;
        send_key(1'b1, 9'h075);
        for (int i = 1; i <= 10; i++) begin
            step(1);
            n_checks++;
            if ({bus.o_dir[3], bus.o_coin} !== 3'b111) begin n_fail++; $display("FAIL post_reset_quiet_%0d: got %b want 111", i, {bus.o_dir[3], bus.o_coin}); end
        end
        send_key(1'b1, 9'h075);
        step(2);
        n_checks++;
        if (bus.o_dir[3] !== 1'b0) begin n_fail++; $display("FAIL post_reset_key: got %b want 0", bus.o_dir[3]); end
        send_key(1'b0, 9'h075);
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_kbd_arrows();
        test_rotation();
        test_coin_stretch();
        test_autofire();
        test_merge_coin_auto();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
